// File: rtl/pc8001_kbd_pkg.sv
// Shared definitions for the PC-8001 keyboard matrix: row/column constants,
// key kinds and the PS/2 set-2 scancode to matrix position table.
package pc8001_kbd_pkg;

    localparam logic [3:0] ROW_LIMIT = 4'd10;
    localparam logic [3:0] ROW_MOD   = 4'd8;
    localparam logic [2:0] COL_KANA  = 3'd5;
    localparam logic [2:0] COL_SHIFT = 3'd6;
    localparam logic [2:0] COL_CTRL  = 3'd7;

    // SHL/SHR mark the left/right source of a shared modifier bit (shift or ctrl)
    typedef enum logic [1:0] {
        KIND_MOM  = 2'd0,
        KIND_SHL  = 2'd1,
        KIND_SHR  = 2'd2,
        KIND_KANA = 2'd3
    } kind_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
        kind_t      kind;
    } key_map_t;

    function automatic key_map_t map_entry(input logic [3:0] row, input logic [2:0] col,
                                           input kind_t kind);
        key_map_t m;
        m.hit  = 1'b1;
        m.row  = row;
        m.col  = col;
        m.kind = kind;
        return m;
    endfunction

    function automatic key_map_t mom(input logic [3:0] row, input logic [2:0] col);
        return map_entry(row, col, KIND_MOM);
    endfunction

    // Index is {E0-extended, scancode}; anything not listed is unmapped (hit=0).
    function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        case ({ext, code})
            // row 0: keypad 0-7
            9'h070: m = mom(4'd0, 3'd0);   9'h069: m = mom(4'd0, 3'd1);
            9'h072: m = mom(4'd0, 3'd2);   9'h07A: m = mom(4'd0, 3'd3);
            9'h06B: m = mom(4'd0, 3'd4);   9'h073: m = mom(4'd0, 3'd5);
            9'h074: m = mom(4'd0, 3'd6);   9'h06C: m = mom(4'd0, 3'd7);
            // row 1: keypad 8,9,*,+, '.', RETURN (keypad = and , have no PS/2 key)
            9'h075: m = mom(4'd1, 3'd0);   9'h07D: m = mom(4'd1, 3'd1);
            9'h07C: m = mom(4'd1, 3'd2);   9'h079: m = mom(4'd1, 3'd3);
            9'h071: m = mom(4'd1, 3'd6);   9'h05A: m = mom(4'd1, 3'd7);
            // row 2: @, A-G
            9'h054: m = mom(4'd2, 3'd0);   9'h01C: m = mom(4'd2, 3'd1);
            9'h032: m = mom(4'd2, 3'd2);   9'h021: m = mom(4'd2, 3'd3);
            9'h023: m = mom(4'd2, 3'd4);   9'h024: m = mom(4'd2, 3'd5);
            9'h02B: m = mom(4'd2, 3'd6);   9'h034: m = mom(4'd2, 3'd7);
            // row 3: H-O
            9'h033: m = mom(4'd3, 3'd0);   9'h043: m = mom(4'd3, 3'd1);
            9'h03B: m = mom(4'd3, 3'd2);   9'h042: m = mom(4'd3, 3'd3);
            9'h04B: m = mom(4'd3, 3'd4);   9'h03A: m = mom(4'd3, 3'd5);
            9'h031: m = mom(4'd3, 3'd6);   9'h044: m = mom(4'd3, 3'd7);
            // row 4: P-W
            9'h04D: m = mom(4'd4, 3'd0);   9'h015: m = mom(4'd4, 3'd1);
            9'h02D: m = mom(4'd4, 3'd2);   9'h01B: m = mom(4'd4, 3'd3);
            9'h02C: m = mom(4'd4, 3'd4);   9'h03C: m = mom(4'd4, 3'd5);
            9'h02A: m = mom(4'd4, 3'd6);   9'h01D: m = mom(4'd4, 3'd7);
            // row 5: X,Y,Z,[,\,],^,-
            9'h022: m = mom(4'd5, 3'd0);   9'h035: m = mom(4'd5, 3'd1);
            9'h01A: m = mom(4'd5, 3'd2);   9'h05B: m = mom(4'd5, 3'd3);
            9'h06A: m = mom(4'd5, 3'd4);   9'h05D: m = mom(4'd5, 3'd5);
            9'h055: m = mom(4'd5, 3'd6);   9'h04E: m = mom(4'd5, 3'd7);
            // row 6: 0-7
            9'h045: m = mom(4'd6, 3'd0);   9'h016: m = mom(4'd6, 3'd1);
            9'h01E: m = mom(4'd6, 3'd2);   9'h026: m = mom(4'd6, 3'd3);
            9'h025: m = mom(4'd6, 3'd4);   9'h02E: m = mom(4'd6, 3'd5);
            9'h036: m = mom(4'd6, 3'd6);   9'h03D: m = mom(4'd6, 3'd7);
            // row 7: 8,9,:,;,comma,.,/,_
            9'h03E: m = mom(4'd7, 3'd0);   9'h046: m = mom(4'd7, 3'd1);
            9'h052: m = mom(4'd7, 3'd2);   9'h04C: m = mom(4'd7, 3'd3);
            9'h041: m = mom(4'd7, 3'd4);   9'h049: m = mom(4'd7, 3'd5);
            9'h04A: m = mom(4'd7, 3'd6);   9'h051: m = mom(4'd7, 3'd7);
            // row 8: CLR(Home), UP, RIGHT, INS/DEL(Bksp), GRPH(Alt), KANA, SHIFT, CTRL
            9'h16C: m = mom(4'd8, 3'd0);   9'h175: m = mom(4'd8, 3'd1);
            9'h174: m = mom(4'd8, 3'd2);   9'h066: m = mom(4'd8, 3'd3);
            9'h011: m = mom(4'd8, 3'd4);
            9'h07E: m = map_entry(ROW_MOD, COL_KANA, KIND_KANA);
            9'h012: m = map_entry(ROW_MOD, COL_SHIFT, KIND_SHL);
            9'h059: m = map_entry(ROW_MOD, COL_SHIFT, KIND_SHR);
            9'h014: m = map_entry(ROW_MOD, COL_CTRL, KIND_SHL);
            9'h114: m = map_entry(ROW_MOD, COL_CTRL, KIND_SHR);
            // row 9: STOP(F12), F1-F5, SPACE, ESC
            9'h007: m = mom(4'd9, 3'd0);   9'h005: m = mom(4'd9, 3'd1);
            9'h006: m = mom(4'd9, 3'd2);   9'h004: m = mom(4'd9, 3'd3);
            9'h00C: m = mom(4'd9, 3'd4);   9'h003: m = mom(4'd9, 3'd5);
            9'h029: m = mom(4'd9, 3'd6);   9'h076: m = mom(4'd9, 3'd7);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pc8001_kbd_decode.sv
// Stage 2: registered scancode lookup.
import pc8001_kbd_pkg::*;

module pc8001_kbd_decode (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_vld,
    input  logic       in_press,
    input  logic       in_ext,
    input  logic [7:0] in_code,
    output logic       out_vld,
    output logic       out_press,
    output key_map_t   out_map
);

    logic     vld_q, vld_d;
    logic     press_q, press_d;
    key_map_t map_q, map_d;

    // Look up the latched event; a flush drops whatever is entering this stage.
    always_comb begin
        vld_d   = in_vld && !flush;
        press_d = in_press;
        map_d   = key_lookup(in_ext, in_code);
    end

    // Stage 2 registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= 1'b0;
            press_q <= 1'b0;
            map_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            press_q <= press_d;
            map_q   <= map_d;
        end
    end

    assign out_vld   = vld_q;
    assign out_press = press_q;
    assign out_map   = map_q;

endmodule

// File: rtl/pc8001_keymatrix.sv
// PC-8001 keyboard matrix fed from hps_io PS/2 key events.
// Pipeline: stage 1 event detect, stage 2 table lookup, stage 3 matrix apply.
import pc8001_kbd_pkg::*;

module pc8001_keymatrix (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        flush,
    input  logic [3:0]  row_sel,
    output logic [7:0]  row_data,
    output logic        any_key,
    output logic        kana_lock,
    output logic        key_evt
);

    logic       arm_q, arm_d;
    logic       tgl_q, tgl_d;
    logic       evt;
    logic       s1_vld_q, s1_vld_d;
    logic       s1_press_q, s1_press_d;
    logic       s1_ext_q, s1_ext_d;
    logic [7:0] s1_code_q, s1_code_d;

    logic       dec_vld;
    logic       dec_press;
    key_map_t   dec_map;

    // src bits: 0 shift-L, 1 shift-R, 2 ctrl-L, 3 ctrl-R
    logic [9:0][7:0] mat_q, mat_d;
    logic [3:0]      src_q, src_d;
    logic [1:0]      src_idx;
    logic            kana_q, kana_d;
    logic            key_evt_q, key_evt_d;
    logic            any_key_q, any_key_d;
    logic [7:0]      row_data_q, row_data_d;

    // Row 8 merges the live momentary bits with the derived modifier/KANA bits.
    function automatic logic [7:0] row_view(input logic [3:0] sel, input logic [9:0][7:0] mat,
                                            input logic [3:0] src, input logic kana);
        logic [7:0] r;
        r = 8'hFF;
        if (sel == ROW_MOD)
            r = {~(src[2] | src[3]), ~(src[0] | src[1]), ~kana, mat[ROW_MOD][4:0]};
        else if (sel < ROW_LIMIT)
            r = mat[sel];
        return r;
    endfunction

    // Stage 1: the first cycle after reset only arms the toggle tracker.
    always_comb begin
        arm_d      = 1'b1;
        tgl_d      = ps2_key[10];
        evt        = arm_q && (ps2_key[10] != tgl_q);
        s1_vld_d   = evt && !flush;
        s1_press_d = s1_press_q;
        s1_ext_d   = s1_ext_q;
        s1_code_d  = s1_code_q;
        if (evt) begin
            s1_press_d = ps2_key[9];
            s1_ext_d   = ps2_key[8];
            s1_code_d  = ps2_key[7:0];
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            arm_q      <= 1'b0;
            tgl_q      <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_press_q <= 1'b0;
            s1_ext_q   <= 1'b0;
            s1_code_q  <= 8'h00;
        end else begin
            arm_q      <= arm_d;
            tgl_q      <= tgl_d;
            s1_vld_q   <= s1_vld_d;
            s1_press_q <= s1_press_d;
            s1_ext_q   <= s1_ext_d;
            s1_code_q  <= s1_code_d;
        end
    end

    pc8001_kbd_decode u_decode (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_vld    (s1_vld_q),
        .in_press  (s1_press_q),
        .in_ext    (s1_ext_q),
        .in_code   (s1_code_q),
        .out_vld   (dec_vld),
        .out_press (dec_press),
        .out_map   (dec_map)
    );

    // Stage 3: apply the decoded event; outputs are built from the next state
    // so a change is visible on row_data in the same cycle key_evt pulses.
    always_comb begin
        mat_d     = mat_q;
        src_d     = src_q;
        kana_d    = kana_q;
        key_evt_d = 1'b0;
        src_idx   = {dec_map.col == COL_CTRL, dec_map.kind == KIND_SHR};
        if (flush) begin
            mat_d = '1;
            src_d = '0;
        end else if (dec_vld && dec_map.hit) begin
            case (dec_map.kind)
                KIND_MOM: begin
                    if (dec_map.row < ROW_LIMIT)
                        mat_d[dec_map.row][dec_map.col] = ~dec_press;
                    key_evt_d = 1'b1;
                end
                KIND_SHL, KIND_SHR: begin
                    src_d[src_idx] = dec_press;
                    key_evt_d      = 1'b1;
                end
                KIND_KANA: begin
                    if (dec_press) begin
                        kana_d    = ~kana_q;
                        key_evt_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        any_key_d  = ~(&mat_d) | (|src_d);
        row_data_d = row_view(row_sel, mat_d, src_d, kana_d);
    end

    // Stage 3 and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mat_q      <= '1;
            src_q      <= '0;
            kana_q     <= 1'b0;
            key_evt_q  <= 1'b0;
            any_key_q  <= 1'b0;
            row_data_q <= 8'hFF;
        end else begin
            mat_q      <= mat_d;
            src_q      <= src_d;
            kana_q     <= kana_d;
            key_evt_q  <= key_evt_d;
            any_key_q  <= any_key_d;
            row_data_q <= row_data_d;
        end
    end

    assign row_data  = row_data_q;
    assign any_key   = any_key_q;
    assign kana_lock = kana_q;
    assign key_evt   = key_evt_q;

endmodule

// File: tb/tb_pc8001_keymatrix.sv
// Self-checking bench for pc8001_keymatrix: directed scenarios plus a random
// event stream compared against a key-position model.
`timescale 1ns/1ps
module tb_pc8001_keymatrix;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'h000;
    logic        flush   = 1'b0;
    logic [3:0]  row_sel = 4'h0;
    logic [7:0]  row_data;
    logic        any_key;
    logic        kana_lock;
    logic        key_evt;

    int n_checks = 0;
    int n_fail   = 0;
    int evt_seen = 0;
    int evt_exp  = 0;

    logic [8:0] tbl [0:9][0:7];
    bit         pressed [0:9][0:7];
    bit         shl, shr, ctl, ctr, kana;

    always #5 clk_sys = ~clk_sys;

    pc8001_keymatrix dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .flush     (flush),
        .row_sel   (row_sel),
        .row_data  (row_data),
        .any_key   (any_key),
        .kana_lock (kana_lock),
        .key_evt   (key_evt)
    );

    always @(negedge clk_sys) if (key_evt === 1'b1) evt_seen++;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // PC-8001 row map in PS/2 set-2 terms, {E0, code}; 0 = no key at that spot.
    // Row 8 cols 5-7 (KANA/SHIFT/CTRL) are handled separately in the model.
    task automatic load_tbl();
        tbl[0] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C};
        tbl[1] = '{9'h075, 9'h07D, 9'h07C, 9'h079, 9'h000, 9'h000, 9'h071, 9'h05A};
        tbl[2] = '{9'h054, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034};
        tbl[3] = '{9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044};
        tbl[4] = '{9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D};
        tbl[5] = '{9'h022, 9'h035, 9'h01A, 9'h05B, 9'h06A, 9'h05D, 9'h055, 9'h04E};
        tbl[6] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D};
        tbl[7] = '{9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h049, 9'h04A, 9'h051};
        tbl[8] = '{9'h16C, 9'h175, 9'h174, 9'h066, 9'h011, 9'h000, 9'h000, 9'h000};
        tbl[9] = '{9'h007, 9'h005, 9'h006, 9'h004, 9'h00C, 9'h003, 9'h029, 9'h076};
    endtask

    task automatic model_reset();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 8; c++) pressed[r][c] = 1'b0;
        shl = 0; shr = 0; ctl = 0; ctr = 0; kana = 0;
    endtask

    task automatic model_flush();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 8; c++) pressed[r][c] = 1'b0;
        shl = 0; shr = 0; ctl = 0; ctr = 0;
    endtask

    task automatic model_event(input bit press, input bit ext, input logic [7:0] code);
        logic [8:0] k;
        k = {ext, code};
        case (k)
            9'h012: begin shl = press; evt_exp++; end
            9'h059: begin shr = press; evt_exp++; end
            9'h014: begin ctl = press; evt_exp++; end
            9'h114: begin ctr = press; evt_exp++; end
            9'h07E: if (press) begin kana = ~kana; evt_exp++; end
            default: begin
                if (k != 9'h000)
                    for (int r = 0; r < 10; r++)
                        for (int c = 0; c < 8; c++)
                            if (tbl[r][c] == k) begin
                                pressed[r][c] = press;
                                evt_exp++;
                            end
            end
        endcase
    endtask

    function automatic logic [7:0] model_row(input int r);
        logic [7:0] v;
        v = 8'hFF;
        if (r < 10)
            for (int c = 0; c < 8; c++) v[c] = ~pressed[r][c];
        if (r == 8) begin
            v[7] = ~(ctl | ctr);
            v[6] = ~(shl | shr);
            v[5] = ~kana;
        end
        return v;
    endfunction

    function automatic bit model_any();
        bit a;
        a = shl | shr | ctl | ctr;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 8; c++) a = a | pressed[r][c];
        return a;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic send(input bit press, input bit ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], press, ext, code};
        model_event(press, ext, code);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic read_row(input logic [3:0] r);
        row_sel = r;
        tick();
    endtask

    task automatic scan_all(input string tag);
        for (int r = 0; r < 16; r++) begin
            read_row(4'(r));
            check_eq($sformatf("%s row%0d", tag, r), row_data, model_row(r));
        end
        check_eq({tag, " any_key"}, any_key, model_any());
        check_eq({tag, " kana_lock"}, kana_lock, kana);
        check_eq({tag, " evt_count"}, evt_seen, evt_exp);
    endtask

    initial begin
        logic [8:0] k;
        int r, c;
        load_tbl();

        // toggle bit high through reset release must not raise an event
        ps2_key = 11'h400;
        do_reset();
        tick();
        scan_all("reset");

        // latency: press A with row 2 selected; visible on the third edge
        read_row(4'd2);
        send(1'b1, 1'b0, 8'h1C);
        tick();
        check_eq("lat_early_row", row_data, 8'hFF);
        check_eq("lat_early_evt", key_evt, 1'b0);
        tick();
        check_eq("lat_row", row_data, 8'hFD);
        check_eq("lat_evt", key_evt, 1'b1);
        tick();
        check_eq("lat_evt_off", key_evt, 1'b0);
        send(1'b0, 1'b0, 8'h1C);
        settle();
        read_row(4'd2);
        check_eq("a_release", row_data, 8'hFF);

        // shift sources
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h59);
        send(1'b0, 1'b0, 8'h12);
        settle();
        read_row(4'd8);
        check_eq("shift_r_held", row_data, 8'hBF);
        send(1'b0, 1'b0, 8'h59);
        settle();
        read_row(4'd8);
        check_eq("shift_none", row_data, 8'hFF);

        // KANA toggle
        send(1'b1, 1'b0, 8'h7E);
        send(1'b0, 1'b0, 8'h7E);
        settle();
        read_row(4'd8);
        check_eq("kana_on_row", row_data, 8'hDF);
        check_eq("kana_on", kana_lock, 1'b1);
        check_eq("kana_on_any", any_key, 1'b0);
        send(1'b1, 1'b0, 8'h7E);
        send(1'b0, 1'b0, 8'h7E);
        settle();
        read_row(4'd8);
        check_eq("kana_off_row", row_data, 8'hFF);
        check_eq("kana_off", kana_lock, 1'b0);
        check_eq("kana_off_any", any_key, 1'b0);

        // flush with KANA on and a toggle arriving during flush
        send(1'b1, 1'b0, 8'h7E);
        send(1'b1, 1'b0, 8'h1C);
        settle();
        flush   = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h32};
        model_flush();
        tick();
        flush = 1'b0;
        settle();
        read_row(4'd2);
        check_eq("flush_row2", row_data, 8'hFF);
        check_eq("flush_kana", kana_lock, 1'b1);
        scan_all("flush");

        // back-to-back events
        send(1'b1, 1'b0, 8'h29);
        send(1'b1, 1'b0, 8'h76);
        settle();
        read_row(4'd9);
        check_eq("b2b_row9", row_data, 8'h3F);
        read_row(4'hC);
        check_eq("row_c", row_data, 8'hFF);

        // reset with an event in flight
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h22};
        tick();
        do_reset();
        settle();
        scan_all("rst_mid");

        // random stream
        for (int i = 0; i < 240; i++) begin
            case ($urandom_range(9))
                0: begin
                    k = 9'($urandom);
                end
                1: begin
                    case ($urandom_range(4))
                        0: k = 9'h012;
                        1: k = 9'h059;
                        2: k = 9'h014;
                        3: k = 9'h114;
                        default: k = 9'h07E;
                    endcase
                end
                default: begin
                    r = $urandom_range(9);
                    c = $urandom_range(7);
                    k = tbl[r][c];
                    if (k == 9'h000) k = 9'h029;
                end
            endcase
            send(1'($urandom), k[8], k[7:0]);
            repeat ($urandom_range(2)) tick();
            if ($urandom_range(29) == 0) begin
                settle();
                flush = 1'b1;
                model_flush();
                tick();
                flush = 1'b0;
            end
            if (i % 24 == 23) begin
                settle();
                scan_all($sformatf("rnd%0d", i));
            end
        end
        settle();
        scan_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
